// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream valid/ready channel carrying a program image into rom_loader
interface rom_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   modport master (output rx_data, rx_valid, input rx_ready);
   modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/rom_loader.sv
// rom_loader: loads a big-endian program stream into the instruction ROM and holds the CPU in reset until done; define ROM_LOADER_CHKSUM_EN for a trailing checksum word
module rom_loader #(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   rom_loader_if.slave       rx,
   input  logic              load_req,
   input  logic [ADDR_W-1:0] pc,
   output logic [15:0]       instruction,
   output logic              cpu_reset,
   output logic              loaded,
   output logic              error,
   output logic [ADDR_W:0]   word_cnt
);
   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
`ifdef ROM_LOADER_CHKSUM_EN
   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, RUN, ERR, CHK_HI, CHK_LO} state_t;
   localparam state_t FIN = CHK_HI;
   logic [15:0] sum_q, sum_d;
`else
   typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA_HI, DATA_LO, RUN, ERR} state_t;
   localparam state_t FIN = RUN;
`endif
   state_t              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [15:0]         rom_q [2**ADDR_W];
   logic                xfer, last, we;
   logic [15:0]         wdata, n_in;
   assign xfer        = rx.rx_valid && rx.rx_ready;
   assign wdata       = {hi_q, rx.rx_data};
   assign n_in        = {len_q[15:8], rx.rx_data};
   assign last        = 17'(cnt_q) + 17'd1 == {1'b0, len_q};
   assign rx.rx_ready = !(state_q inside {RUN, ERR});
   assign cpu_reset   = state_q != RUN;
   assign loaded      = state_q == RUN;
   assign error       = state_q == ERR;
   assign word_cnt    = cnt_q;
   assign instruction = rom_q[pc];
   // Control state and load bookkeeping; async reset leaves the ROM untouched
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= LEN_HI;
         len_q   <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
`ifdef ROM_LOADER_CHKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
`ifdef ROM_LOADER_CHKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
   // Next state; load_req wins over any byte arriving in the same cycle
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
`ifdef ROM_LOADER_CHKSUM_EN
      sum_d   = sum_q;
`endif
      if (load_req) begin
         state_d = LEN_HI;
         cnt_d   = '0;
`ifdef ROM_LOADER_CHKSUM_EN
         sum_d   = '0;
`endif
      end else if (xfer) begin
         case (state_q)
            LEN_HI: begin
               len_d[15:8] = rx.rx_data;
               state_d     = LEN_LO;
            end
            LEN_LO: begin
               len_d[7:0] = rx.rx_data;
               state_d    = ({1'b0, n_in} > DEPTH) ? ERR : (n_in == '0) ? FIN : DATA_HI;
            end
            DATA_HI: begin
               hi_d    = rx.rx_data;
               state_d = DATA_LO;
            end
            DATA_LO: begin
               we      = 1'b1;
               cnt_d   = cnt_q + (ADDR_W+1)'(1);
               state_d = last ? FIN : DATA_HI;
`ifdef ROM_LOADER_CHKSUM_EN
               sum_d   = sum_q + wdata;
`endif
            end
`ifdef ROM_LOADER_CHKSUM_EN
            CHK_HI: begin
               hi_d    = rx.rx_data;
               state_d = CHK_LO;
            end
            CHK_LO: state_d = (wdata == sum_q) ? RUN : ERR;
`endif
            default: ;
         endcase
      end
   end
   // ROM write port; word index is the count of words already stored
   always_ff @(posedge clk) begin
      if (we) rom_q[cnt_q[ADDR_W-1:0]] <= wdata;
   end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed plus randomized streams against an array model of the ROM; honours ROM_LOADER_CHKSUM_EN
module tb_rom_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_req = 1'b0;
   logic [14:0] pc_m = '0;
   logic [3:0]  pc_s = '0;
   logic [15:0] instr_m, instr_s;
   logic        cr_m, cr_s, ld_m, ld_s, er_m, er_s;
   logic [15:0] wc_m;
   logic [4:0]  wc_s;
   int          checks = 0, errors = 0;
   logic [15:0] mrom [int];
   logic [15:0] w [$];

   rom_loader_if ifm ();
   rom_loader_if ifs ();

   rom_loader #(.ADDR_W(15)) dut (
      .clk(clk), .reset(reset), .rx(ifm), .load_req(load_req), .pc(pc_m),
      .instruction(instr_m), .cpu_reset(cr_m), .loaded(ld_m), .error(er_m), .word_cnt(wc_m)
   );
   rom_loader #(.ADDR_W(4)) dut_s (
      .clk(clk), .reset(reset), .rx(ifs), .load_req(load_req), .pc(pc_s),
      .instruction(instr_s), .cpu_reset(cr_s), .loaded(ld_s), .error(er_s), .word_cnt(wc_s)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rdy(input bit s);  return s ? 32'(ifs.rx_ready) : 32'(ifm.rx_ready); endfunction
   function automatic logic [31:0] crs(input bit s);  return s ? 32'(cr_s) : 32'(cr_m); endfunction
   function automatic logic [31:0] lds(input bit s);  return s ? 32'(ld_s) : 32'(ld_m); endfunction
   function automatic logic [31:0] ers(input bit s);  return s ? 32'(er_s) : 32'(er_m); endfunction
   function automatic logic [31:0] wcs(input bit s);  return s ? 32'(wc_s) : 32'(wc_m); endfunction
   function automatic logic [31:0] ins(input bit s);  return s ? 32'(instr_s) : 32'(instr_m); endfunction
   function automatic int key(input bit s, input int a); return s ? 65536 + a : a; endfunction

   task automatic drive(input bit s, input logic v, input logic [7:0] d);
      if (s) begin ifs.rx_valid = v; ifs.rx_data = d; end
      else begin ifm.rx_valid = v; ifm.rx_data = d; end
   endtask

   task automatic send(input bit s, input logic [7:0] b, input bit gaps);
      for (int k = 0; k < 3 && gaps && $urandom_range(1, 0) == 1; k++) begin
         drive(s, 1'b0, 8'($urandom));
         step();
      end
      drive(s, 1'b1, b);
      chk("rx_ready_load", rdy(s), 1);
      chk("cpu_reset_load", crs(s), 1);
      step();
      drive(s, 1'b0, b);
   endtask

   task automatic req();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      chk("req_rx_ready", rdy(0), 1);
      chk("req_cpu_reset", crs(0), 1);
      chk("req_word_cnt", wcs(0), 0);
      chk("req_error", ers(0), 0);
   endtask

   task automatic load(input bit s, input logic [15:0] ws [$], input bit gaps);
      logic [15:0] n;
`ifdef ROM_LOADER_CHKSUM_EN
      logic [15:0] sum = '0;
`endif
      n = 16'(ws.size());
      send(s, n[15:8], gaps);
      send(s, n[7:0], gaps);
      foreach (ws[i]) begin
         send(s, ws[i][15:8], gaps);
         send(s, ws[i][7:0], gaps);
         mrom[key(s, i)] = ws[i];
`ifdef ROM_LOADER_CHKSUM_EN
         sum += ws[i];
`endif
      end
`ifdef ROM_LOADER_CHKSUM_EN
      send(s, sum[15:8], gaps);
      send(s, sum[7:0], gaps);
`endif
      chk("run_cpu_reset", crs(s), 0);
      chk("run_loaded", lds(s), 1);
      chk("run_error", ers(s), 0);
      chk("run_word_cnt", wcs(s), 32'(n));
      chk("run_rx_ready", rdy(s), 0);
   endtask

   task automatic verify(input bit s, input string tag);
      foreach (mrom[k]) begin
         if ((k >= 65536) == s) begin
            if (s) pc_s = 4'(k % 65536);
            else pc_m = 15'(k % 65536);
            #1;
            chk(tag, ins(s), 32'(mrom[k]));
         end
      end
   endtask

   initial begin
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      #2 reset = 1'b0;
      step();
      step();
      chk("rst_cpu_reset", crs(0), 1);
      chk("rst_loaded", lds(0), 0);
      chk("rst_error", ers(0), 0);
      chk("rst_word_cnt", wcs(0), 0);
      chk("rst_rx_ready", rdy(0), 1);
      chk("rst_rx_ready_s", rdy(1), 1);
      reset = 1'b1;
      step();
      w = '{16'h1234, 16'hABCD};
      load(0, w, 1'b0);
      verify(0, "rom_basic");
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b1, 8'($urandom));
         step();
      end
      drive(0, 1'b0, 8'h00);
      chk("run_ignore_loaded", lds(0), 1);
      chk("run_ignore_wc", wcs(0), 2);
      verify(0, "rom_run_ignore");
      req();
      load(0, w, 1'b1);
      verify(0, "rom_gaps");
      req();
      w = {};
      load(0, w, 1'b1);
      verify(0, "rom_len0");
      repeat (3) begin
         req();
         w = {};
         for (int i = $urandom_range(12, 1); i > 0; i--) w.push_back(16'($urandom));
         load(0, w, 1'b1);
         verify(0, "rom_rand");
      end
      req();
      send(0, 8'h00, 1'b0);
      send(0, 8'h03, 1'b0);
      send(0, 8'h77, 1'b0);
      chk("abort_mid_wc", wcs(0), 0);
      chk("abort_mid_loaded", lds(0), 0);
      drive(0, 1'b1, 8'h00);
      req();
      drive(0, 1'b0, 8'h00);
      w = '{16'h0005};
      load(0, w, 1'b1);
      verify(0, "rom_abort");
      #2 reset = 1'b0;
      #1;
      chk("async_cpu_reset", crs(0), 1);
      chk("async_loaded", lds(0), 0);
      chk("async_word_cnt", wcs(0), 0);
      step();
      reset = 1'b1;
      verify(0, "rom_kept_reset");
      send(0, 8'h80, 1'b0);
      send(0, 8'h01, 1'b0);
      chk("big_error", ers(0), 1);
      chk("big_cpu_reset", crs(0), 1);
      chk("big_rx_ready", rdy(0), 0);
      chk("big_loaded", lds(0), 0);
      req();
      send(1, 8'h00, 1'b0);
      send(1, 8'h11, 1'b0);
      chk("s17_error", ers(1), 1);
      chk("s17_cpu_reset", crs(1), 1);
      chk("s17_rx_ready", rdy(1), 0);
      req();
      chk("s_req_error", ers(1), 0);
      chk("s_req_rx_ready", rdy(1), 1);
      w = {};
      for (int i = 0; i < 16; i++) w.push_back(16'($urandom));
      load(1, w, 1'b1);
      verify(1, "rom_full_s");
`ifdef ROM_LOADER_CHKSUM_EN
      req();
      w = '{16'h0001, 16'h0002};
      load(0, w, 1'b0);
      req();
      send(0, 8'h00, 1'b0); send(0, 8'h02, 1'b0);
      send(0, 8'h00, 1'b0); send(0, 8'h01, 1'b0);
      send(0, 8'h00, 1'b0); send(0, 8'h02, 1'b0);
      send(0, 8'h00, 1'b0); send(0, 8'h04, 1'b0);
      chk("chk_bad_error", ers(0), 1);
      chk("chk_bad_loaded", lds(0), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Upstream neighbour of the Hack CPU core: owns the instruction ROM and drives the core's `instruction` and `reset` inputs.
- Receives a program as a byte stream over a valid/ready handshake and writes it into an internal 16-bit-wide ROM.
- Holds the CPU in reset until the load completes, then serves `instruction = rom[pc]` combinationally each cycle.
- Supports reloading the program at runtime without a full system reset.

Parameters:
- ADDR_W, 15, ROM address width; ROM depth = 2**ADDR_W words, matching the 15-bit CPU pc.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming program byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- load_req  input  1  single-cycle pulse requesting a (re)load.
- pc  input  ADDR_W  instruction address from the CPU.
- instruction  output  16  rom[pc], combinational read.
- cpu_reset  output  1  active-high reset for the CPU core.
- loaded  output  1  high while in RUN.
- error  output  1  high while in ERR.
- word_cnt  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- A byte transfers only on a clock edge where rx_valid && rx_ready.
- Stream format, all big-endian:
  - two bytes: word count N;
  - then N words, high byte first;
  - then one checksum word, only when the optional feature is enabled.
- Reset (reset==0, immediate):
  - state=LEN_HI; cpu_reset=1; loaded=0; error=0; word_cnt=0; rx_ready=1.
  - ROM contents are not cleared.
- State machine:
  - LEN_HI: on transfer, latch N[15:8]; go to LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. Then:
    - N > 2**ADDR_W: go to ERR;
    - N == 0: go to RUN (or CHK_HI if the feature is enabled);
    - otherwise go to DATA_HI.
  - DATA_HI: on transfer, latch the high byte; go to DATA_LO.
  - DATA_LO: on transfer, write {hi, rx_data} to rom[word_cnt[ADDR_W-1:0]] and increment word_cnt.
    - If word_cnt+1 == N: go to RUN (or CHK_HI if the feature is enabled).
    - Otherwise: go to DATA_HI.
  - RUN: rx_ready=0; cpu_reset=0; loaded=1.
  - ERR: rx_ready=0; cpu_reset=1; error=1.
- load_req:
  - Honoured in every state, including mid-load.
  - Next state is LEN_HI; word_cnt=0; error=0; cpu_reset=1.
  - A byte transferred in the same cycle as load_req is discarded.
  - ROM words already written are kept.
- Timing:
  - cpu_reset falls on the same edge that enters RUN. The CPU's first fetch, at pc=0, happens on the following cycle.
  - A ROM write is visible on `instruction` from the edge after the write.
- Unloaded ROM locations (index >= N) return their prior contents.
- rx_valid with rx_ready=0 is ignored; the loader does not buffer it.
- Word count range: N = 2**ADDR_W is legal and fills the ROM exactly. word_cnt is ADDR_W+1 bits wide so it can represent N.

Optional Feature:
- Macro: ROM_LOADER_CHKSUM_EN.
- Defined:
  - A running sum, mod 2**16, of all data words is kept.
  - After the last data word, states CHK_HI and CHK_LO receive one checksum word.
  - If the checksum equals the sum, go to RUN; otherwise go to ERR.
  - With N==0 the expected checksum is 0x0000.
  - The sum clears on reset and on load_req.
- Undefined:
  - No checksum states or sum logic exist.
  - The loader enters RUN directly after the last data word.

Test Plan:
- Reset released, stream 00 02 | 12 34 | AB CD -> cpu_reset=1 throughout the load, then 0 the edge after byte CD. word_cnt=2; pc=0 gives 0x1234; pc=1 gives 0xABCD; rx_ready=0.
- rx_valid toggled 0/1 on alternate cycles during the same stream -> identical ROM contents. No byte is lost or duplicated, and only cycles with rx_valid&&rx_ready advance the state.
- Length 00 00 -> RUN on the LEN_LO edge; word_cnt=0; instruction at pc=0 keeps its prior value (0x1234 after the first test).
- ADDR_W=4 build, length 00 11 (17 > 16) -> ERR: error=1, cpu_reset=1, rx_ready=0. A load_req pulse then gives error=0, state LEN_HI, rx_ready=1.
- load_req pulsed in RUN and again after 3 bytes of a new stream -> the second pulse aborts. A fresh stream 00 01 | 00 05 gives pc=0 → 0x0005; word_cnt=1.
- With ROM_LOADER_CHKSUM_EN, stream 00 02 | 00 01 | 00 02 | 00 03 -> RUN. Same data with checksum 00 04 -> ERR, error=1.
